sum_frame_accumulator: RTL and testbench
========================================

Name: sum_frame_accumulator

Overview:
- Downstream consumer of the pipelined 32-bit adder's sum stream.
- Sums a programmable number of consecutive adder results (a "frame") into a wide accumulator.
- Emits one total per frame on a valid/ready output.
- The adder has no backpressure, so this block buffers up to 2 completed totals and flags any total it must drop.

Parameters:
DATA_W, 32, width of incoming sum (matches adder output)
ACC_W, 40, accumulator/total width; must be > DATA_W
LEN_W, 8, width of frame-length field

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  in_data carries a new adder result this cycle; no ready, never stalled
in_data  input  DATA_W  adder sum, unsigned
frame_len  input  LEN_W  beats per frame; sampled only on the first beat of a frame; 0 treated as 1
out_valid  output  1  output FIFO non-empty
out_ready  input  1  downstream accepts head entry
out_sum  output  ACC_W  frame total (head entry)
out_len  output  LEN_W  effective beat count of that frame (1..2^LEN_W-1)
out_ovf  output  1  accumulator wrapped during that frame
busy  output  1  a frame is partially accumulated (state ACCUM)
drop_err  output  1  one-cycle pulse: completed total discarded, FIFO full

Behaviour:
- Reset (async assert, sync release): state IDLE, acc=0, beat count=0, FIFO empty, out_valid=0, out_sum=0, out_len=0, out_ovf=0, busy=0, drop_err=0. Any partial frame is discarded.
- Arithmetic: in_data zero-extended to ACC_W, unsigned add, modulo 2^ACC_W. out_ovf is sticky per frame and set on any carry out of bit ACC_W-1.
- FSM states: IDLE, ACCUM.
- IDLE, in_valid=0: stay.
- IDLE, in_valid=1:
  - latch L = (frame_len==0 ? 1 : frame_len); acc <= in_data; ovf <= 0; cnt <= 1.
  - If L==1: complete immediately (push in_data, len 1, ovf 0) and stay IDLE.
  - Else go to ACCUM.
- ACCUM, in_valid=0: hold; gaps of any length allowed.
- ACCUM, in_valid=1: acc <= acc+in_data; cnt <= cnt+1.
  - If cnt+1==L: push {acc+in_data, L, ovf|carry}, go to IDLE, clear acc/cnt/ovf.
- Back-to-back frames: the beat in the cycle after a completing beat starts a new frame with no bubble. frame_len is re-sampled at that beat.
- frame_len changes mid-frame are ignored.
- Output FIFO (2 entries, first-word fall-through):
  - out_* reflect the head; out_valid=1 iff count>0.
  - Pop on out_valid&&out_ready.
  - out_* must stay stable while out_valid=1 and out_ready=0.
- Latency: completing beat on edge t -> out_valid=1 after edge t+1 when FIFO was empty; 0 cycles of extra bubble.
- Push with FIFO full and simultaneous pop: push accepted, count stays 2, no drop.
- Push with FIFO full and no pop: new total discarded, drop_err=1 for exactly one cycle, FIFO contents unchanged. Accumulation of the next frame is unaffected.
- Push with FIFO empty and out_ready=1 in the same cycle: entry appears next cycle (no combinational bypass).
- busy=1 iff state==ACCUM.
- Reset asserted mid-frame or with FIFO occupied: everything cleared immediately; no output emitted for the partial frame.

Test Plan:
- Reset then frame_len=4, in_data 1,2,3,4 on consecutive cycles, out_ready=1 -> one out_valid pulse, out_sum=10, out_len=4, out_ovf=0, one cycle after the 4th beat.
- frame_len=0, single beat in_data=0xFFFFFFFF -> out_sum=0x00FFFFFFFF, out_len=1; frame_len=2 with beats 5, (3 idle cycles), 7 -> out_sum=12; busy high only during the gap.
- ACC_W=33 build, frame_len=3, three beats of 0xFFFFFFFF -> out_sum=0x0FFFFFFFD (mod 2^33), out_ovf=1; next frame 1+1 -> out_ovf=0.
- out_ready=0, three consecutive len=1 frames of 10, 20, 30 -> FIFO holds 10, 20; drop_err pulses once on the third; out_sum stable at 10; then out_ready=1 -> 10, 20 delivered in order.
- FIFO full with out_ready=1 in the same cycle a new total completes -> no drop_err, order preserved, count stays 2.
- Assert rst after 2 of 4 beats with one entry queued -> out_valid=0 and busy=0 immediately; post-reset frame of 4,4 (len 2) -> out_sum=8 (no residue).

Source files
------------

// File: rtl/sum_frame_accumulator.sv
// Sums frames of consecutive adder results into a wide total and queues up to two
// finished totals in a first-word fall-through FIFO; totals that find it full are dropped.
module sum_frame_accumulator #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 40,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [LEN_W-1:0]  frame_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [LEN_W-1:0]  out_len,
    output logic              out_ovf,
    output logic              busy,
    output logic              drop_err
);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [LEN_W-1:0]   cnt;
    logic [LEN_W-1:0]   len_lat;
    logic               ovf;

    logic               push_v;
    logic [ACC_W-1:0]   push_sum;
    logic [LEN_W-1:0]   push_len;
    logic               push_ovf;

    logic [ACC_W-1:0]   in_ext;
    logic [ACC_W-1:0]   sum_next;
    logic               carry;
    logic [LEN_W-1:0]   eff_len;
    logic [LEN_W-1:0]   cnt_next;

    logic [ACC_W-1:0]   mem_sum [2];
    logic [LEN_W-1:0]   mem_len [2];
    logic               mem_ovf [2];
    logic               rd_ptr;
    logic               wr_ptr;
    logic [1:0]         count;
    logic               pop;
    logic               push_ok;

    always_comb begin
        in_ext             = ACC_W'(in_data);
        {carry, sum_next}  = {1'b0, acc} + {1'b0, in_ext};
        eff_len            = (frame_len == '0) ? LEN_W'(1) : frame_len;
        cnt_next           = cnt + LEN_W'(1);
        pop                = (count != 2'd0) && out_ready;
        push_ok            = push_v && ((count != 2'd2) || pop);
    end

    // Frame accumulation; a finished total goes through one register stage before the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            len_lat  <= '0;
            ovf      <= 1'b0;
            push_v   <= 1'b0;
            push_sum <= '0;
            push_len <= '0;
            push_ovf <= 1'b0;
        end else begin
            push_v <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        len_lat <= eff_len;
                        ovf     <= 1'b0;
                        if (eff_len == LEN_W'(1)) begin
                            push_v   <= 1'b1;
                            push_sum <= in_ext;
                            push_len <= LEN_W'(1);
                            push_ovf <= 1'b0;
                            acc      <= '0;
                            cnt      <= '0;
                        end else begin
                            acc   <= in_ext;
                            cnt   <= LEN_W'(1);
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        if (cnt_next == len_lat) begin
                            push_v   <= 1'b1;
                            push_sum <= sum_next;
                            push_len <= len_lat;
                            push_ovf <= ovf | carry;
                            acc      <= '0;
                            cnt      <= '0;
                            ovf      <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            acc <= sum_next;
                            cnt <= cnt_next;
                            ovf <= ovf | carry;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-entry FIFO; a simultaneous pop frees the slot a push into a full FIFO needs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_sum[i] <= '0;
                mem_len[i] <= '0;
                mem_ovf[i] <= 1'b0;
            end
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
            drop_err <= 1'b0;
        end else begin
            drop_err <= push_v && !push_ok;
            if (push_ok) begin
                mem_sum[wr_ptr] <= push_sum;
                mem_len[wr_ptr] <= push_len;
                mem_ovf[wr_ptr] <= push_ovf;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign out_valid = (count != 2'd0);
    assign out_sum   = mem_sum[rd_ptr];
    assign out_len   = mem_len[rd_ptr];
    assign out_ovf   = mem_ovf[rd_ptr];
    assign busy      = (state == ACCUM);

endmodule

// File: tb/tb_sum_frame_accumulator.sv
// Directed bench for sum_frame_accumulator: a default-width instance plus a 33-bit
// accumulator instance for wrap checks, with hand-computed expected totals.
module tb_sum_frame_accumulator;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic [7:0]  frame_len;
    logic        out_ready;
    logic        sel33;

    logic        in_valid_a;
    logic        out_valid_a;
    logic [39:0] out_sum_a;
    logic [7:0]  out_len_a;
    logic        out_ovf_a;
    logic        busy_a;
    logic        drop_err_a;

    logic        in_valid_b;
    logic        out_valid_b;
    logic [32:0] out_sum_b;
    logic [7:0]  out_len_b;
    logic        out_ovf_b;
    logic        busy_b;
    logic        drop_err_b;

    int errors = 0;
    int checks = 0;

    assign in_valid_a = in_valid & ~sel33;
    assign in_valid_b = in_valid & sel33;

    sum_frame_accumulator dut (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_data(in_data),
        .frame_len(frame_len), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_sum(out_sum_a), .out_len(out_len_a), .out_ovf(out_ovf_a),
        .busy(busy_a), .drop_err(drop_err_a)
    );

    sum_frame_accumulator #(.DATA_W(32), .ACC_W(33), .LEN_W(8)) dut33 (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_data(in_data),
        .frame_len(frame_len), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_sum(out_sum_b), .out_len(out_len_b), .out_ovf(out_ovf_b),
        .busy(busy_b), .drop_err(drop_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one input cycle; it is sampled on the next rising edge, after which we return.
    task automatic applyStimulus(input logic v, input logic [31:0] data, input logic [7:0] len);
        in_valid  = v;
        in_data   = data;
        frame_len = len;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        frame_len = '0;
        out_ready = 1'b1;
        sel33     = 1'b0;
        idleCycles(2);

        $display("[TB] reset state");
        checkOutput("rst_out_valid", 64'(out_valid_a), 64'd0);
        checkOutput("rst_out_sum",   64'(out_sum_a),   64'd0);
        checkOutput("rst_out_len",   64'(out_len_a),   64'd0);
        checkOutput("rst_busy",      64'(busy_a),      64'd0);
        checkOutput("rst_drop_err",  64'(drop_err_a),  64'd0);
        rst = 1'b0;
        idleCycles(1);

        $display("[TB] frame of four beats 1..4");
        applyStimulus(1'b1, 32'd1, 8'd4);
        applyStimulus(1'b1, 32'd2, 8'd4);
        checkOutput("f4_busy_mid", 64'(busy_a), 64'd1);
        applyStimulus(1'b1, 32'd3, 8'd4);
        applyStimulus(1'b1, 32'd4, 8'd4);
        checkOutput("f4_busy_done",  64'(busy_a),      64'd0);
        checkOutput("f4_no_bypass",  64'(out_valid_a), 64'd0);
        idleCycles(1);
        checkOutput("f4_valid", 64'(out_valid_a), 64'd1);
        checkOutput("f4_sum",   64'(out_sum_a),   64'd10);
        checkOutput("f4_len",   64'(out_len_a),   64'd4);
        checkOutput("f4_ovf",   64'(out_ovf_a),   64'd0);
        idleCycles(1);
        checkOutput("f4_popped", 64'(out_valid_a), 64'd0);

        $display("[TB] zero length treated as one, and gapped frame");
        applyStimulus(1'b1, 32'hFFFF_FFFF, 8'd0);
        checkOutput("l0_busy", 64'(busy_a), 64'd0);
        idleCycles(1);
        checkOutput("l0_valid", 64'(out_valid_a), 64'd1);
        checkOutput("l0_sum",   64'(out_sum_a),   64'h00_FFFF_FFFF);
        checkOutput("l0_len",   64'(out_len_a),   64'd1);
        applyStimulus(1'b1, 32'd5, 8'd2);
        checkOutput("gap_busy_start", 64'(busy_a), 64'd1);
        applyStimulus(1'b0, 32'd99, 8'd9);
        applyStimulus(1'b0, 32'd99, 8'd9);
        applyStimulus(1'b0, 32'd99, 8'd9);
        checkOutput("gap_busy_hold", 64'(busy_a),      64'd1);
        checkOutput("gap_no_output", 64'(out_valid_a), 64'd0);
        applyStimulus(1'b1, 32'd7, 8'd1);
        checkOutput("gap_busy_end", 64'(busy_a), 64'd0);
        idleCycles(1);
        checkOutput("gap_sum", 64'(out_sum_a), 64'd12);
        checkOutput("gap_len", 64'(out_len_a), 64'd2);
        idleCycles(1);

        $display("[TB] 33-bit accumulator wrap");
        sel33 = 1'b1;
        applyStimulus(1'b1, 32'hFFFF_FFFF, 8'd3);
        applyStimulus(1'b1, 32'hFFFF_FFFF, 8'd3);
        applyStimulus(1'b1, 32'hFFFF_FFFF, 8'd3);
        idleCycles(1);
        checkOutput("w33_valid", 64'(out_valid_b), 64'd1);
        checkOutput("w33_sum",   64'(out_sum_b),   64'h0_FFFF_FFFD);
        checkOutput("w33_len",   64'(out_len_b),   64'd3);
        checkOutput("w33_ovf",   64'(out_ovf_b),   64'd1);
        applyStimulus(1'b1, 32'd1, 8'd2);
        applyStimulus(1'b1, 32'd1, 8'd2);
        idleCycles(1);
        checkOutput("w33_next_sum", 64'(out_sum_b), 64'd2);
        checkOutput("w33_next_ovf", 64'(out_ovf_b), 64'd0);
        idleCycles(1);
        sel33 = 1'b0;

        $display("[TB] FIFO full with stalled output");
        out_ready = 1'b0;
        applyStimulus(1'b1, 32'd10, 8'd1);
        applyStimulus(1'b1, 32'd20, 8'd1);
        applyStimulus(1'b1, 32'd30, 8'd1);
        checkOutput("full_head", 64'(out_sum_a),  64'd10);
        checkOutput("full_drop_before", 64'(drop_err_a), 64'd0);
        idleCycles(1);
        checkOutput("full_drop_pulse", 64'(drop_err_a), 64'd1);
        checkOutput("full_head_stable", 64'(out_sum_a), 64'd10);
        idleCycles(1);
        checkOutput("full_drop_once", 64'(drop_err_a), 64'd0);
        out_ready = 1'b1;
        checkOutput("drain_first", 64'(out_sum_a), 64'd10);
        idleCycles(1);
        checkOutput("drain_second_valid", 64'(out_valid_a), 64'd1);
        checkOutput("drain_second", 64'(out_sum_a), 64'd20);
        idleCycles(1);
        checkOutput("drain_empty", 64'(out_valid_a), 64'd0);

        $display("[TB] FIFO full with simultaneous pop");
        out_ready = 1'b0;
        applyStimulus(1'b1, 32'd100, 8'd1);
        applyStimulus(1'b1, 32'd200, 8'd1);
        applyStimulus(1'b1, 32'd300, 8'd1);
        out_ready = 1'b1;
        idleCycles(1);
        checkOutput("pp_no_drop", 64'(drop_err_a), 64'd0);
        checkOutput("pp_head",    64'(out_sum_a),  64'd200);
        idleCycles(1);
        checkOutput("pp_third_valid", 64'(out_valid_a), 64'd1);
        checkOutput("pp_third", 64'(out_sum_a), 64'd300);
        idleCycles(1);
        checkOutput("pp_empty", 64'(out_valid_a), 64'd0);

        $display("[TB] reset mid-frame with an entry queued");
        out_ready = 1'b0;
        applyStimulus(1'b1, 32'd50, 8'd1);
        applyStimulus(1'b1, 32'd4, 8'd4);
        applyStimulus(1'b1, 32'd4, 8'd4);
        checkOutput("pre_rst_valid", 64'(out_valid_a), 64'd1);
        checkOutput("pre_rst_busy",  64'(busy_a),      64'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_valid", 64'(out_valid_a), 64'd0);
        checkOutput("rst_mid_busy",  64'(busy_a),      64'd0);
        idleCycles(1);
        rst       = 1'b0;
        out_ready = 1'b1;
        applyStimulus(1'b1, 32'd4, 8'd2);
        applyStimulus(1'b1, 32'd4, 8'd2);
        idleCycles(1);
        checkOutput("post_rst_sum", 64'(out_sum_a), 64'd8);
        checkOutput("post_rst_len", 64'(out_len_a), 64'd2);
        idleCycles(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
